// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver, majority-vote bit recovery,
// optional parity, one-cycle data_valid / par_err / stp_err pulses.
module uart_rx_core #(
  parameter int Data_Len  = 8,
  parameter int Presc_Len = 6
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RX_IN,
  input  logic                 PAR_EN,
  input  logic                 PAR_TYP,
  input  logic [Presc_Len-1:0] Prescale,
  output logic [Data_Len-1:0]  P_DATA,
  output logic                 data_valid,
  output logic                 par_err,
  output logic                 stp_err
);
  localparam int BW = (Data_Len > 1) ? $clog2(Data_Len) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t               r_state, w_next;
  logic                 r_rx_meta, r_rx_s;
  logic [Presc_Len-1:0] r_presc, r_edge_cnt, w_half;
  logic [BW-1:0]        r_bit_cnt;
  logic [Data_Len-1:0]  r_shift;
  logic [2:0]           r_smp;
  logic                 r_par_en, r_par_typ, r_par_mis;
  logic                 w_bit, w_bit_end, w_last_data;
  assign w_half      = r_presc >> 1;
  assign w_bit       = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_smp[2]) | (r_smp[1] & r_smp[2]);
  assign w_bit_end   = r_edge_cnt == r_presc - Presc_Len'(1);
  assign w_last_data = r_bit_cnt == BW'(Data_Len - 1);
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = r_rx_s ? IDLE : START;
      START:   if (w_bit_end) w_next = w_bit ? IDLE : DATA;
      DATA:    if (w_bit_end && w_last_data) w_next = r_par_en ? PARITY : STOP;
      PARITY:  if (w_bit_end) w_next = STOP;
      STOP:    if (w_bit_end) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rx_meta  <= 1'b1;
      r_rx_s     <= 1'b1;
      r_presc    <= '0;
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_smp      <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_par_mis  <= 1'b0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      r_rx_meta  <= RX_IN;
      r_rx_s     <= r_rx_meta;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      r_edge_cnt <= (r_state == IDLE || w_bit_end) ? '0 : r_edge_cnt + Presc_Len'(1);
      if (r_edge_cnt == w_half - Presc_Len'(1)) r_smp[0] <= r_rx_s;
      if (r_edge_cnt == w_half)                 r_smp[1] <= r_rx_s;
      if (r_edge_cnt == w_half + Presc_Len'(1)) r_smp[2] <= r_rx_s;
      if (r_state == IDLE && !r_rx_s) begin
        r_presc   <= Prescale;
        r_par_en  <= PAR_EN;
        r_par_typ <= PAR_TYP;
        r_par_mis <= 1'b0;
      end
      if (r_state == START && w_bit_end) r_bit_cnt <= '0;
      if (r_state == DATA && w_bit_end) begin
        r_shift   <= {w_bit, r_shift[Data_Len-1:1]};
        r_bit_cnt <= r_bit_cnt + BW'(1);
      end
      if (r_state == PARITY && w_bit_end) r_par_mis <= w_bit != (^r_shift ^ r_par_typ);
      // result is registered on the stop-bit boundary, so pulses appear the cycle after
      if (r_state == STOP && w_bit_end) begin
        if (w_bit && !r_par_mis) begin
          P_DATA     <= r_shift;
          data_valid <= 1'b1;
        end else begin
          par_err <= r_par_mis;
          stp_err <= !w_bit;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed frames with hand-computed results for uart_rx_core.
module tb_uart_rx_core;
  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic [7:0] P_DATA;
  logic       data_valid, par_err, stp_err;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int t_a, t_b;
  uart_rx_core #(.Data_Len(8), .Presc_Len(6)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .Prescale(Prescale), .P_DATA(P_DATA), .data_valid(data_valid),
    .par_err(par_err), .stp_err(stp_err)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_quiet(input string tag);
    chk({tag, " dv"}, data_valid, 0);
    chk({tag, " pe"}, par_err, 0);
    chk({tag, " se"}, stp_err, 0);
  endtask
  // called at #1 after edge 0; returns at #1 after edge N*T; config is
  // scrambled after the start bit to show it is latched at detection
  task automatic send(input int t, input logic [7:0] d, input logic pe, input logic pt,
                      input logic pbit, input logic sbit);
    Prescale = 6'(t);
    PAR_EN   = pe;
    PAR_TYP  = pt;
    RX_IN    = 1'b0;
    repeat (t) @(posedge CLK);
    #1;
    Prescale = (t == 8) ? 6'd16 : 6'd8;
    PAR_EN   = ~pe;
    PAR_TYP  = ~pt;
    for (int i = 0; i < 8; i++) begin
      RX_IN = d[i];
      repeat (t) @(posedge CLK);
      #1;
    end
    if (pe) begin
      RX_IN = pbit;
      repeat (t) @(posedge CLK);
      #1;
    end
    RX_IN = sbit;
    repeat (t) @(posedge CLK);
    #1;
    RX_IN = 1'b1;
  endtask
  // pulse expected in the cycle after edge N*T+3+lag, quiet on either side
  task automatic check_pulse(input string tag, input logic dv, input logic pe, input logic se,
                             input logic [7:0] pd, input int lag, output int t_at);
    repeat (2 + lag) @(posedge CLK);
    #1;
    chk_quiet({tag, " before"});
    @(posedge CLK);
    #1;
    t_at = cyc;
    chk({tag, " dv"}, data_valid, dv);
    chk({tag, " pe"}, par_err, pe);
    chk({tag, " se"}, stp_err, se);
    chk({tag, " pdata"}, P_DATA, pd);
    @(posedge CLK);
    #1;
    chk_quiet({tag, " after"});
    chk({tag, " pdata hold"}, P_DATA, pd);
  endtask
  initial begin
    #1;
    chk("reset pdata", P_DATA, 8'h00);
    chk_quiet("reset");
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk_quiet("idle");
    send(8, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    check_pulse("a5", 1'b1, 1'b0, 1'b0, 8'hA5, 0, t_a);
    send(16, 8'h0F, 1'b1, 1'b0, 1'b1, 1'b1);
    check_pulse("0f badpar", 1'b0, 1'b1, 1'b0, 8'hA5, 0, t_a);
    send(16, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b1);
    check_pulse("0f goodpar", 1'b1, 1'b0, 1'b0, 8'h0F, 0, t_a);
    send(8, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);
    check_pulse("3c badstop", 1'b0, 1'b0, 1'b1, 8'h0F, 0, t_a);
    send(8, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
    check_pulse("3c bothbad", 1'b0, 1'b1, 1'b1, 8'h0F, 0, t_a);
    RX_IN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RX_IN = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge CLK);
      #1;
      chk_quiet("glitch");
    end
    chk("glitch pdata", P_DATA, 8'h0F);
    send(8, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
    check_pulse("81", 1'b1, 1'b0, 1'b0, 8'h81, 0, t_a);
    send(16, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    fork
      check_pulse("b2b first", 1'b1, 1'b0, 1'b0, 8'h3C, 0, t_a);
      send(16, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1);
    join
    check_pulse("b2b second", 1'b1, 1'b0, 1'b0, 8'hC3, 1, t_b);
    chk("b2b gap", t_b - t_a, 161);
    fork
      send(8, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
      begin
        repeat (30) @(posedge CLK);
        #1;
        chk("pre-reset pdata", P_DATA, 8'hC3);
        #2;
        RST = 1'b0;
        #1;
        chk("async reset pdata", P_DATA, 8'h00);
        chk_quiet("async reset");
      end
    join
    RST = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK);
      #1;
      chk_quiet("post reset");
    end
    chk("post reset pdata", P_DATA, 8'h00);
    send(8, 8'h66, 1'b0, 1'b0, 1'b0, 1'b1);
    check_pulse("66", 1'b1, 1'b0, 1'b0, 8'h66, 0, t_a);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
